// File: rtl/alu_muldiv_if.sv
`timescale 1ns/1ps
// alu_muldiv_if: request/response handshake bundle for the multiply/divide unit
interface alu_muldiv_if #(parameter int XLEN = 32);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            kill;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] result;
    logic            busy;
    modport master (
        output req_valid, op, src_a, src_b, kill, rsp_ready,
        input  req_ready, rsp_valid, result, busy
    );
    modport slave (
        input  req_valid, op, src_a, src_b, kill, rsp_ready,
        output req_ready, rsp_valid, result, busy
    );
endinterface

// File: rtl/alu_muldiv.sv
`timescale 1ns/1ps
// alu_muldiv: iterative radix-2 RV32M multiply/divide unit with valid/ready handshakes and kill
module alu_muldiv #(
    parameter int XLEN         = 32,
    parameter bit FAST_SPECIAL = 1'b1
) (
    input logic         clk_i,
    input logic         rst_i,
    alu_muldiv_if.slave bus
);
    localparam int CW = $clog2(XLEN);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [2*XLEN-1:0] acc_q, acc_d, acc_step, prod;
    logic [XLEN-1:0]   opnd_q, opnd_d, res_q, res_d;
    logic              neg_q, neg_d, spec_q, spec_d;
    logic              is_div, sign_a, sign_b, div_zero, ovf;
    logic [XLEN-1:0]   mag_a, mag_b, spec_res, div_val, fin_res;
    logic [XLEN:0]     mul_sum, div_cand, div_diff;

    // request decode: operand signedness, magnitudes and the fixed results of the special divides
    always_comb begin
        is_div   = bus.op[2];
        sign_a   = bus.src_a[XLEN-1] & (is_div ? ~bus.op[0] : bus.op[1] ^ bus.op[0]);
        sign_b   = bus.src_b[XLEN-1] & (is_div ? ~bus.op[0] : bus.op[1:0] == 2'b01);
        mag_a    = sign_a ? -bus.src_a : bus.src_a;
        mag_b    = sign_b ? -bus.src_b : bus.src_b;
        div_zero = is_div && bus.src_b == '0;
        ovf      = is_div && !bus.op[0] && bus.src_a == {1'b1, {(XLEN-1){1'b0}}} && &bus.src_b;
        spec_res = div_zero ? (bus.op[1] ? bus.src_a : '1) : (bus.op[1] ? '0 : bus.src_a);
    end

    // one radix-2 step (shift-add multiply or restoring divide) and the sign-corrected final result
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_cand = acc_q[2*XLEN-1:XLEN-1];
        div_diff = div_cand - {1'b0, opnd_q};
        acc_step = !op_q[2]       ? {mul_sum, acc_q[XLEN-1:1]}
                 : div_diff[XLEN] ? {div_cand[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                 :                  {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        prod     = neg_q ? -acc_step : acc_step;
        div_val  = op_q[1] ? acc_step[2*XLEN-1:XLEN] : acc_step[XLEN-1:0];
        fin_res  = op_q[2] ? (neg_q ? -div_val : div_val)
                 : op_q[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    // control: accept in IDLE, iterate in BUSY, hold the result in DONE; kill aborts BUSY/DONE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        res_d   = res_q;
        neg_d   = neg_q;
        spec_d  = spec_q;
        if (state_q == IDLE) begin
            if (bus.req_valid) begin
                op_d    = bus.op;
                acc_d   = {{XLEN{1'b0}}, is_div ? mag_a : mag_b};
                opnd_d  = is_div ? mag_b : mag_a;
                neg_d   = (is_div && bus.op[1]) ? sign_a : sign_a ^ sign_b;
                spec_d  = div_zero || ovf;
                res_d   = spec_res;
                cnt_d   = CW'(XLEN - 1);
                state_d = (spec_d && FAST_SPECIAL) ? DONE : BUSY;
            end
        end else if (bus.kill) begin
            state_d = IDLE;
        end else if (state_q == BUSY) begin
            acc_d = acc_step;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
                state_d = DONE;
                res_d   = spec_q ? res_q : fin_res;
            end
        end else if (bus.rsp_ready) begin
            state_d = IDLE;
        end
    end

    // state and datapath registers, cleared by reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            res_q   <= '0;
            neg_q   <= 1'b0;
            spec_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            res_q   <= res_d;
            neg_q   <= neg_d;
            spec_q  <= spec_d;
        end
    end

    assign bus.req_ready = state_q == IDLE;
    assign bus.rsp_valid = state_q == DONE;
    assign bus.busy      = state_q != IDLE;
    assign bus.result    = state_q == DONE ? res_q : '0;
endmodule

// File: tb/tb_alu_muldiv.sv
`timescale 1ns/1ps
// tb_alu_muldiv: directed and randomized check of both FAST_SPECIAL variants against an arithmetic model
module tb_alu_muldiv;
    localparam int          XLEN = 32;
    localparam logic [31:0] MIN  = 32'h8000_0000;

    logic        clk = 1'b0, rst = 1'b1;
    logic        valid = 1'b0, kill = 1'b0, rsp_ready = 1'b1;
    logic [2:0]  op = '0;
    logic [31:0] a = '0, b = '0;
    int          bp_mode = 0;
    int          errors = 0, checks = 0;
    bit          started = 1'b0;
    bit          pend [2];
    int          el [2];
    int          lat [2];
    logic [31:0] expv [2];

    alu_muldiv_if #(.XLEN(XLEN)) bus0 ();
    alu_muldiv_if #(.XLEN(XLEN)) bus1 ();

    assign bus0.req_valid = valid;
    assign bus0.op        = op;
    assign bus0.src_a     = a;
    assign bus0.src_b     = b;
    assign bus0.kill      = kill;
    assign bus0.rsp_ready = rsp_ready;
    assign bus1.req_valid = valid;
    assign bus1.op        = op;
    assign bus1.src_a     = a;
    assign bus1.src_b     = b;
    assign bus1.kill      = kill;
    assign bus1.rsp_ready = rsp_ready;

    alu_muldiv #(.XLEN(XLEN), .FAST_SPECIAL(1'b1)) dut0 (.clk_i(clk), .rst_i(rst), .bus(bus0));
    alu_muldiv #(.XLEN(XLEN), .FAST_SPECIAL(1'b0)) dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1));

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx = longint'($signed(x));
        longint      sy = longint'($signed(y));
        longint      uy = longint'({32'b0, y});
        logic [63:0] p;
        case (o)
            3'd0, 3'd1: p = 64'(sx * sy);
            3'd2:       p = 64'(sx * uy);
            3'd3:       p = {32'b0, x} * {32'b0, y};
            3'd4:       return (y == '0) ? 32'hFFFF_FFFF : 32'(sx / sy);
            3'd5:       return (y == '0) ? 32'hFFFF_FFFF : x / y;
            3'd6:       return (y == '0) ? x : 32'(sx % sy);
            default:    return (y == '0) ? x : x % y;
        endcase
        return (o == 3'd0) ? p[31:0] : p[63:32];
    endfunction

    function automatic bit is_spec(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        return o[2] && (y == '0 || (!o[0] && x == MIN && y == 32'hFFFF_FFFF));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // transaction model per DUT: pending flag, edges since accept, required latency, expected result
    initial forever begin
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rst) pend[d] = 1'b0;
            else if (pend[d]) begin
                if (kill || (el[d] >= lat[d] && rsp_ready)) pend[d] = 1'b0;
                else el[d]++;
            end else if (valid) begin
                pend[d] = 1'b1;
                el[d]   = 1;
                lat[d]  = (d == 0 && is_spec(op, a, b)) ? 1 : XLEN + 1;
                expv[d] = ref_res(op, a, b);
            end
        end
        if (rst) started = 1'b1;
    end

    task automatic cmp(input int d, input logic v, input logic r, input logic bz, input logic [31:0] res);
        bit ev;
        ev = pend[d] && el[d] >= lat[d];
        chk($sformatf("valid_o[%0d]", d), 32'(v), 32'(ev));
        chk($sformatf("ready_o[%0d]", d), 32'(r), 32'(!pend[d]));
        chk($sformatf("busy_o[%0d]", d), 32'(bz), 32'(pend[d]));
        chk($sformatf("result_o[%0d]", d), res, ev ? expv[d] : 32'h0);
    endtask

    // every-cycle comparison of both DUTs against the model
    initial forever begin
        @(negedge clk);
        if (started) begin
            cmp(0, bus0.rsp_valid, bus0.req_ready, bus0.busy, bus0.result);
            cmp(1, bus1.rsp_valid, bus1.req_ready, bus1.busy, bus1.result);
        end
    end

    // response backpressure: 0 always ready, 1 stalled, 2 random
    initial forever begin
        @(posedge clk);
        #2;
        rsp_ready = bp_mode == 0 ? 1'b1 : bp_mode == 1 ? 1'b0 : 1'($urandom_range(0, 1));
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((pend[0] || pend[1]) && n < 300) begin
            tick();
            n++;
        end
        chk("done_within_bound", 32'(pend[0] || pend[1]), 32'h0);
        if (pend[0] || pend[1]) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input bit with_kill);
        int n = 0;
        while (!(bus0.req_ready && bus1.req_ready) && n < 100) begin
            tick();
            n++;
        end
        chk("ready_before_issue", 32'(bus0.req_ready && bus1.req_ready), 32'h1);
        op    = o;
        a     = x;
        b     = y;
        valid = 1'b1;
        kill  = with_kill;
        tick();
        valid = 1'b0;
        kill  = 1'b0;
        op    = 3'($urandom);
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic run_dir(input string name, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] req, input int lat_fast);
        bit got0 = 1'b0, got1 = 1'b0;
        int n = 1;
        issue(o, x, y, 1'b0);
        while (!(got0 && got1) && n < 100) begin
            if (!got0 && bus0.rsp_valid) begin
                got0 = 1'b1;
                chk({name, " fast result"}, bus0.result, req);
                chk({name, " fast latency"}, 32'(n), 32'(lat_fast));
            end
            if (!got1 && bus1.rsp_valid) begin
                got1 = 1'b1;
                chk({name, " slow result"}, bus1.result, req);
                chk({name, " slow latency"}, 32'(n), 32'(XLEN + 1));
            end
            if (!(got0 && got1)) begin
                tick();
                n++;
            end
        end
        chk({name, " completed"}, 32'(got0 && got1), 32'h1);
        wait_idle();
    endtask

    initial begin
        logic [31:0] held;
        logic [2:0]  ro;
        logic [31:0] rx, ry;
        int          n, r;
        chk("model MUL", ref_res(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
        chk("model MULHSU", ref_res(3'd2, 32'hFFFF_FFFF, 32'd2), 32'hFFFF_FFFF);
        chk("model DIV ovf", ref_res(3'd4, MIN, 32'hFFFF_FFFF), MIN);
        chk("model REM", ref_res(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
        repeat (2) tick();
        rst = 1'b0;
        chk("reset ready", 32'(bus0.req_ready && bus1.req_ready), 32'h1);
        chk("reset valid", 32'(bus0.rsp_valid || bus1.rsp_valid), 32'h0);

        run_dir("MUL", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_dir("MULH", 3'd1, MIN, MIN, 32'h4000_0000, 33);
        run_dir("MULHU", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_dir("MULHSU", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33);
        run_dir("DIV", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_dir("REM", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_dir("DIVU", 3'd5, 32'd100, 32'd7, 32'd14, 33);
        run_dir("REMU", 3'd7, 32'd100, 32'd7, 32'd2, 33);
        run_dir("DIV by 0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_dir("REMU by 0", 3'd7, 32'd5, 32'd0, 32'd5, 1);
        run_dir("DIV ovf", 3'd4, MIN, 32'hFFFF_FFFF, MIN, 1);
        run_dir("REM ovf", 3'd6, MIN, 32'hFFFF_FFFF, 32'd0, 1);

        bp_mode = 1;
        issue(3'd0, 32'd123456, 32'd789, 1'b0);
        n = 0;
        while (!bus0.rsp_valid && n < 60) begin
            tick();
            n++;
        end
        held = bus0.result;
        repeat (5) begin
            tick();
            chk("backpressure result", bus0.result, held);
            chk("backpressure valid", 32'(bus0.rsp_valid), 32'h1);
            chk("backpressure ready", 32'(bus0.req_ready), 32'h0);
        end
        bp_mode = 0;
        wait_idle();

        issue(3'd5, 32'd1000, 32'd3, 1'b0);
        repeat (9) tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        chk("kill ready", 32'(bus0.req_ready && bus1.req_ready), 32'h1);
        chk("kill valid", 32'(bus0.rsp_valid || bus1.rsp_valid), 32'h0);
        repeat (3) tick();
        run_dir("after kill", 3'd5, 32'd1000, 32'd3, 32'd333, 33);

        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        chk("idle kill ignored", 32'(bus0.busy && bus1.busy), 32'h1);
        wait_idle();

        issue(3'd0, 32'd5, 32'd6, 1'b0);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid reset valid", 32'(bus0.rsp_valid || bus1.rsp_valid), 32'h0);
        chk("mid reset result", bus0.result | bus1.result, 32'h0);
        chk("mid reset ready", 32'(bus0.req_ready && bus1.req_ready), 32'h1);
        run_dir("MUL after reset", 3'd0, 32'd3, 32'd4, 32'd12, 33);

        bp_mode = 2;
        for (int i = 0; i < 60; i++) begin
            ro = 3'($urandom_range(0, 7));
            rx = $urandom;
            ry = $urandom;
            r  = $urandom_range(0, 9);
            if (r == 0) ry = '0;
            if (r == 1) begin
                rx = MIN;
                ry = 32'hFFFF_FFFF;
            end
            if (r == 2) ry = 32'($urandom_range(1, 5));
            if (r == 3) rx = 32'($urandom_range(0, 50));
            issue(ro, rx, ry, 1'b0);
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(0, 40)) tick();
                kill = 1'b1;
                tick();
                kill = 1'b0;
            end
            wait_idle();
        end
        bp_mode = 0;
        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
